// File: rtl/fetch_controller_if.sv
// Signal bundle between the fetch controller and its program counter,
// instruction memory and downstream consumer.
interface fetch_controller_if #(
    parameter int COUNT_W = 16
);
    // program counter
    logic [7:0]         pc_addr;
    logic               pc_halt;
    logic               pc_branch;
    logic [7:0]         pc_offset;

    // instruction memory
    logic               imem_req;
    logic [7:0]         imem_addr;
    logic               imem_ready;
    logic [8:0]         imem_rdata;

    // execution side
    logic               cond_flag;
    logic               instr_valid;
    logic [8:0]         instr_out;
    logic               instr_ack;
    logic               halted;
    logic [COUNT_W-1:0] retired_count;

    modport master (
        input  pc_addr,
        input  imem_ready,
        input  imem_rdata,
        input  cond_flag,
        input  instr_ack,
        output pc_halt,
        output pc_branch,
        output pc_offset,
        output imem_req,
        output imem_addr,
        output instr_valid,
        output instr_out,
        output halted,
        output retired_count
    );

    modport slave (
        output pc_addr,
        output imem_ready,
        output imem_rdata,
        output cond_flag,
        output instr_ack,
        input  pc_halt,
        input  pc_branch,
        input  pc_offset,
        input  imem_req,
        input  imem_addr,
        input  instr_valid,
        input  instr_out,
        input  halted,
        input  retired_count
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch/issue sequencer: fetches one instruction word, resolves branches locally,
// hands everything else downstream and stalls the program counter until it retires.
module fetch_controller #(
    parameter int COUNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_controller_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        OP_NORMAL = 2'd0,
        OP_BRANCH = 2'd1,
        OP_COND   = 2'd2,
        OP_HALT   = 2'd3
    } op_t;

    localparam logic [8:0] HALT_WORD  = 9'b101_111111;
    localparam logic [2:0] BRANCH_OPC = 3'b110;
    localparam logic [2:0] COND_OPC   = 3'b111;

    state_t             state;
    state_t             state_next;
    logic [8:0]         ir;
    logic [COUNT_W-1:0] count;
    op_t                op;
    logic [7:0]         offset_sext;
    logic               retire;

    logic               pc_halt;
    logic               pc_branch;
    logic [7:0]         pc_offset;
    logic               imem_req;
    logic               instr_valid;
    logic               halted;

    // Decode is purely a function of IR, so it is stable for the whole ISSUE stay.
    always_comb begin
        offset_sext = {{2{ir[5]}}, ir[5:0]};
        if (ir == HALT_WORD) begin
            op = OP_HALT;
        end else if (ir[8:6] == BRANCH_OPC) begin
            op = OP_BRANCH;
        end else if (ir[8:6] == COND_OPC) begin
            op = OP_COND;
        end else begin
            op = OP_NORMAL;
        end
    end

    // NOTE: sequential state uses non-blocking assignments and an async reset in the
    // sensitivity list, so every register clears the instant reset rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir <= '0;
        end else if (state == FETCH && bus.imem_ready) begin
            ir <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (retire) begin
            count <= count + COUNT_W'(1);
        end
    end

    // NOTE: every output of this block gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_next  = state;
        retire      = 1'b0;
        pc_halt     = 1'b1;
        pc_branch   = 1'b0;
        pc_offset   = '0;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;

        unique case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                unique case (op)
                    OP_BRANCH: begin
                        pc_halt    = 1'b0;
                        pc_branch  = 1'b1;
                        pc_offset  = offset_sext;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    OP_COND: begin
                        pc_halt    = 1'b0;
                        pc_branch  = bus.cond_flag;
                        pc_offset  = bus.cond_flag ? offset_sext : 8'h00;
                        retire     = 1'b1;
                        state_next = FETCH;
                    end
                    OP_HALT: begin
                        retire     = 1'b1;
                        state_next = HALTED;
                    end
                    default: begin
                        instr_valid = 1'b1;
                        if (bus.instr_ack) begin
                            pc_halt    = 1'b0;
                            retire     = 1'b1;
                            state_next = FETCH;
                        end
                    end
                endcase
            end

            HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.pc_halt       = pc_halt;
    assign bus.pc_branch     = pc_branch;
    assign bus.pc_offset     = pc_offset;
    assign bus.imem_req      = imem_req;
    assign bus.imem_addr     = bus.pc_addr;
    assign bus.instr_valid   = instr_valid;
    assign bus.instr_out     = ir;
    assign bus.halted        = halted;
    assign bus.retired_count = count;

    // A stalled PC must never see a stale branch request.
    a_halt_quiet: assert property (@(posedge clk) disable iff (reset)
        pc_halt |-> (!pc_branch && pc_offset == 8'h00));

    a_single_retire: assert property (@(posedge clk) disable iff (reset)
        !pc_halt |-> state == ISSUE);

    a_req_only_fetch: assert property (@(posedge clk) disable iff (reset)
        imem_req |-> state == FETCH);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: a vector table of single-instruction
// transactions plus hand sequences for reset and HALT behaviour.
module tb_fetch_controller;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    pc;
    logic [CW-1:0] exp_count;
    int            n_checks = 0;
    int            n_fail   = 0;

    always #5 clk = ~clk;

    fetch_controller_if #(.COUNT_W(CW)) bus ();

    fetch_controller #(.COUNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.pc_addr = pc;

    typedef struct {
        logic [8:0] word;
        logic [7:0] addr;
        int         mem_lat;
        int         ack_lat;
        logic       cond;
        logic [7:0] exp_pc;
        logic       exp_branch;
        logic [7:0] exp_off;
        logic       exp_valid;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // One instruction from FETCH through its completion edge; the PC model steps
    // only on cycles where pc_halt was seen low.
    task automatic run_vec(input vec_t v);
        int         issue_cycles = 0;
        bit         done = 1'b0;
        logic       got_branch = 1'b0;
        logic [7:0] got_off = 8'h00;
        logic [7:0] next_pc = 8'h00;

        pc = v.addr;
        bus.cond_flag  = v.cond;
        bus.imem_ready = 1'b0;
        bus.instr_ack  = 1'b0;

        for (int i = 0; i < v.mem_lat; i++) begin
            #1;
            check("fetch_req", bus.imem_req, 1);
            check("fetch_addr", bus.imem_addr, v.addr);
            check("fetch_halt", bus.pc_halt, 1);
            @(posedge clk); #1;
        end

        bus.imem_ready = 1'b1;
        bus.imem_rdata = v.word;
        #1;
        check("fetch_req_ready", bus.imem_req, 1);
        @(posedge clk); #1;
        // A stray ready with a different word during ISSUE must not reload IR.
        bus.imem_rdata = 9'h155;

        for (int k = 0; k < 20 && !done; k++) begin
            bus.instr_ack = (k >= v.ack_lat);
            #1;
            check("issue_valid", bus.instr_valid, v.exp_valid);
            if (v.exp_valid) check("issue_out", bus.instr_out, v.word);
            if (!bus.pc_halt) begin
                done         = 1'b1;
                got_branch   = bus.pc_branch;
                got_off      = bus.pc_offset;
                next_pc      = bus.pc_branch ? pc + bus.pc_offset : pc + 8'd1;
                issue_cycles = k + 1;
            end else begin
                check("stall_no_branch", {bus.pc_branch, bus.pc_offset}, 0);
            end
            @(posedge clk); #1;
        end

        bus.instr_ack  = 1'b0;
        bus.imem_ready = 1'b0;
        if (done) pc = next_pc;
        exp_count++;

        check("completed", done, 1);
        check("issue_cycles", issue_cycles, v.exp_valid ? v.ack_lat + 1 : 1);
        check("pc_branch", got_branch, v.exp_branch);
        check("pc_offset", got_off, v.exp_off);
        check("pc_next", pc, v.exp_pc);
        check("retired_count", bus.retired_count, exp_count);
        check("back_in_fetch", bus.imem_req, 1);
    endtask

    initial begin
        vecs[0]  = '{9'h001,        8'd0,   0, 0, 1'b0, 8'd1,   1'b0, 8'h00, 1'b1};
        vecs[1]  = '{9'b110_010100, 8'd5,   0, 0, 1'b0, 8'd25,  1'b1, 8'd20, 1'b0};
        vecs[2]  = '{9'b111_110110, 8'd30,  0, 0, 1'b1, 8'd20,  1'b1, 8'hF6, 1'b0};
        vecs[3]  = '{9'b111_110110, 8'd30,  0, 0, 1'b0, 8'd31,  1'b0, 8'h00, 1'b0};
        vecs[4]  = '{9'h0A5,        8'd40,  4, 3, 1'b0, 8'd41,  1'b0, 8'h00, 1'b1};
        vecs[5]  = '{9'b110_000000, 8'd50,  0, 0, 1'b0, 8'd50,  1'b1, 8'h00, 1'b0};
        vecs[6]  = '{9'b110_100000, 8'd10,  1, 0, 1'b0, 8'd234, 1'b1, 8'hE0, 1'b0};
        vecs[7]  = '{9'b111_011111, 8'd255, 0, 0, 1'b1, 8'd30,  1'b1, 8'h1F, 1'b0};
        vecs[8]  = '{9'h17E,        8'd100, 0, 1, 1'b0, 8'd101, 1'b0, 8'h00, 1'b1};
        vecs[9]  = '{9'h13F,        8'd255, 2, 0, 1'b1, 8'd0,   1'b0, 8'h00, 1'b1};
        vecs[10] = '{9'b111_000101, 8'd7,   2, 0, 1'b0, 8'd8,   1'b0, 8'h00, 1'b0};

        reset          = 1'b1;
        pc             = 8'h3C;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 9'h000;
        bus.cond_flag  = 1'b0;
        bus.instr_ack  = 1'b0;
        exp_count      = '0;

        #12;
        check("rst_pc_halt", bus.pc_halt, 1);
        check("rst_pc_branch", bus.pc_branch, 0);
        check("rst_pc_offset", bus.pc_offset, 0);
        check("rst_imem_req", bus.imem_req, 0);
        check("rst_imem_addr", bus.imem_addr, 8'h3C);
        check("rst_instr_valid", bus.instr_valid, 0);
        check("rst_instr_out", bus.instr_out, 0);
        check("rst_halted", bus.halted, 0);
        check("rst_retired", bus.retired_count, 0);

        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("idle_no_req", bus.imem_req, 0);
        @(posedge clk); #1;
        check("first_fetch_req", bus.imem_req, 1);
        check("first_fetch_addr", bus.imem_addr, 8'h3C);

        // Two passes so the narrow retire counter wraps.
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 11; i++) begin
                run_vec(vecs[i]);
            end
        end

        // Reset while waiting in FETCH.
        pc = 8'h77;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        exp_count = '0;
        check("rf_imem_req", bus.imem_req, 0);
        check("rf_pc_halt", bus.pc_halt, 1);
        check("rf_retired", bus.retired_count, exp_count);
        check("rf_instr_out", bus.instr_out, 0);
        check("rf_imem_addr", bus.imem_addr, 8'h77);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("rf_idle", bus.imem_req, 0);
        @(posedge clk); #1;
        check("rf_fetch_req", bus.imem_req, 1);
        check("rf_fetch_addr", bus.imem_addr, 8'h77);

        // Reset while a normal instruction waits for its ack.
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 9'h0C3;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        #1;
        check("ri_valid_before", bus.instr_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("ri_valid", bus.instr_valid, 0);
        check("ri_pc_halt", bus.pc_halt, 1);
        check("ri_instr_out", bus.instr_out, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("ri_retired", bus.retired_count, 0);
        check("ri_fetch_req", bus.imem_req, 1);

        // HALT word retires once, then every input is ignored.
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 9'h17F;
        @(posedge clk); #1;
        bus.imem_ready = 1'b0;
        bus.instr_ack  = 1'b1;
        #1;
        check("halt_issue_pc_halt", bus.pc_halt, 1);
        check("halt_issue_valid", bus.instr_valid, 0);
        check("halt_issue_halted", bus.halted, 0);
        @(posedge clk); #1;
        bus.instr_ack = 1'b0;
        check("halted", bus.halted, 1);
        check("halt_retired", bus.retired_count, 1);
        for (int i = 0; i < 6; i++) begin
            bus.imem_ready = i[0];
            bus.instr_ack  = ~i[0];
            bus.cond_flag  = i[1];
            bus.imem_rdata = 9'h1C5;
            #1;
            check("hold_halted", bus.halted, 1);
            check("hold_pc_halt", bus.pc_halt, 1);
            check("hold_branch", bus.pc_branch, 0);
            check("hold_imem_req", bus.imem_req, 0);
            check("hold_valid", bus.instr_valid, 0);
            check("hold_retired", bus.retired_count, 1);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
